// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for a small ARMv8 (LEGv8) integer subset.
//
// Sequences FETCH -> EXEC -> (MEM -> WB) -> FETCH and drives a 32-bit datapath
// control word. The instruction register and the extended immediate k are captured
// in FETCH when instruction memory completes (mem_ready=1). Any opcode outside
// the supported set parks the FSM in HALT, which only reset can leave.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low
//   instruction  instruction-memory read data, sampled in FETCH
//   status       ALU flags {V,C,N,Z}, bit0 = Z; used combinationally in EXEC
//   mem_ready    memory handshake, high when the current access completes
//   k            registered extended immediate (DATA_WIDTH bits)
//   controlWord  datapath control word
//   state        FETCH=0, EXEC=1, MEM=2, WB=3, HALT=4
//   halted       high while in HALT
module multicycle_control_unit #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter bit          ENABLE_BCOND = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           instruction,
  input  logic [3:0]            status,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] k,
  output logic [31:0]           controlWord,
  output logic [2:0]            state,
  output logic                  halted
);

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StExec  = 3'd1,
    StMem   = 3'd2,
    StWb    = 3'd3,
    StHalt  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    OpR, OpI, OpLdur, OpStur, OpB, OpCbz, OpCbnz, OpBcond, OpIll
  } op_e;

  // Field order from MSB (IL, bit 31) down to DA (bits 4:0).
  typedef struct packed {
    logic       il;
    logic       pcsel;
    logic       selb;
    logic       sl;
    logic [1:0] ps;
    logic       en_pc;
    logic       en_b;
    logic       en_alu;
    logic       en_mem;
    logic       wm;
    logic       wr;
    logic [4:0] fs;
    logic [4:0] sb;
    logic [4:0] sa;
    logic [4:0] da;
  } ctrl_t;

  localparam logic [10:0] OpcAdd   = 11'b10001011000;
  localparam logic [10:0] OpcSub   = 11'b11001011000;
  localparam logic [10:0] OpcAnd   = 11'b10001010000;
  localparam logic [10:0] OpcOrr   = 11'b10101010000;
  localparam logic [10:0] OpcLdur  = 11'b11111000010;
  localparam logic [10:0] OpcStur  = 11'b11111000000;
  localparam logic [9:0]  OpcAddi  = 10'b1001000100;
  localparam logic [9:0]  OpcSubi  = 10'b1101000100;
  localparam logic [9:0]  OpcAndi  = 10'b1001001000;
  localparam logic [9:0]  OpcOrri  = 10'b1011001000;
  localparam logic [5:0]  OpcB     = 6'b000101;
  localparam logic [7:0]  OpcCbz   = 8'b10110100;
  localparam logic [7:0]  OpcCbnz  = 8'b10110101;
  localparam logic [7:0]  OpcBcond = 8'b01010100;

  localparam logic [4:0] FsAnd   = 5'b00000;
  localparam logic [4:0] FsOrr   = 5'b00100;
  localparam logic [4:0] FsAdd   = 5'b01000;
  localparam logic [4:0] FsSub   = 5'b01001;
  localparam logic [4:0] FsPassB = 5'b01100;

  localparam logic [1:0] PsHold   = 2'b00;
  localparam logic [1:0] PsInc    = 2'b01;
  localparam logic [1:0] PsBranch = 2'b10;

  function automatic op_e decode_op(input logic [31:0] insn);
    if (insn[31:21] == OpcAdd || insn[31:21] == OpcSub ||
        insn[31:21] == OpcAnd || insn[31:21] == OpcOrr) begin
      return OpR;
    end
    if (insn[31:22] == OpcAddi || insn[31:22] == OpcSubi ||
        insn[31:22] == OpcAndi || insn[31:22] == OpcOrri) begin
      return OpI;
    end
    if (insn[31:21] == OpcLdur) return OpLdur;
    if (insn[31:21] == OpcStur) return OpStur;
    if (insn[31:26] == OpcB)    return OpB;
    if (insn[31:24] == OpcCbz)  return OpCbz;
    if (insn[31:24] == OpcCbnz) return OpCbnz;
    // With B.cond support disabled the encoding falls through to illegal.
    if (insn[31:24] == OpcBcond && ENABLE_BCOND) return OpBcond;
    return OpIll;
  endfunction

  // ALU function for R- and I-type arithmetic/logic ops; ADD/ADDI is the fallback.
  function automatic logic [4:0] decode_fs(input logic [31:0] insn);
    if (insn[31:21] == OpcSub || insn[31:22] == OpcSubi) return FsSub;
    if (insn[31:21] == OpcAnd || insn[31:22] == OpcAndi) return FsAnd;
    if (insn[31:21] == OpcOrr || insn[31:22] == OpcOrri) return FsOrr;
    return FsAdd;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ext_imm(input op_e op, input logic [31:0] insn);
    logic [DATA_WIDTH-1:0] imm;
    case (op)
      OpI:                    imm = {{(DATA_WIDTH-12){1'b0}}, insn[21:10]};
      OpLdur, OpStur:         imm = {{(DATA_WIDTH-9){insn[20]}}, insn[20:12]};
      OpB:                    imm = {{(DATA_WIDTH-26){insn[25]}}, insn[25:0]};
      OpCbz, OpCbnz, OpBcond: imm = {{(DATA_WIDTH-19){insn[23]}}, insn[23:5]};
      default:                imm = '0;
    endcase
    return imm;
  endfunction

  // Even condition codes test the base predicate, odd ones its inverse; 111x always.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic z, n, c, v, base;
    z = flags[0];
    n = flags[1];
    c = flags[2];
    v = flags[3];
    case (cond[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (cond[3:1] == 3'b111) ? 1'b1 : (base ^ cond[0]);
  endfunction

  state_e                state_q, state_d;
  logic [31:0]           ir_q, ir_d;
  logic [DATA_WIDTH-1:0] k_q, k_d;
  ctrl_t                 cw;
  op_e                   ir_op, fetch_op;
  logic [4:0]            rd, rn, rm;

  assign ir_op    = decode_op(ir_q);
  assign fetch_op = decode_op(instruction);
  assign rd       = ir_q[4:0];   // Rd / Rt
  assign rn       = ir_q[9:5];
  assign rm       = ir_q[20:16];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      ir_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    k_d     = k_q;
    cw      = '0;
    case (state_q)
      StFetch: begin
        cw.il = 1'b1;
        if (mem_ready) begin
          ir_d    = instruction;
          k_d     = ext_imm(fetch_op, instruction);
          state_d = StExec;
        end
      end

      StExec: begin
        state_d = StFetch;
        unique case (ir_op)
          OpR, OpI: begin
            cw.da     = rd;
            cw.sa     = rn;
            cw.sb     = rm;
            cw.fs     = decode_fs(ir_q);
            cw.en_alu = 1'b1;
            cw.wr     = 1'b1;
            cw.ps     = PsInc;
            cw.selb   = (ir_op == OpI);
          end
          OpLdur, OpStur: begin
            // Address = Rn + k; PC is held until the memory access retires.
            cw.sa     = rn;
            cw.selb   = 1'b1;
            cw.fs     = FsAdd;
            cw.en_alu = 1'b1;
            cw.ps     = PsHold;
            if (ir_op == OpStur) cw.sb = rd;
            state_d   = StMem;
          end
          OpB: begin
            cw.ps = PsBranch;
          end
          OpCbz, OpCbnz: begin
            cw.sb     = rd;
            cw.fs     = FsPassB;
            cw.en_alu = 1'b1;
            // CBZ branches on Z=1, CBNZ on Z=0.
            cw.ps     = ((ir_op == OpCbz) == status[0]) ? PsBranch : PsInc;
          end
          OpBcond: begin
            cw.ps = cond_holds(ir_q[3:0], status) ? PsBranch : PsInc;
          end
          default: begin
            state_d = StHalt;
          end
        endcase
      end

      StMem: begin
        cw.en_mem = 1'b1;
        if (ir_op == OpStur) begin
          cw.wm = 1'b1;
          cw.sb = rd;
          // A store retires in MEM, so the PC advances on its completing cycle.
          if (mem_ready) begin
            cw.ps   = PsInc;
            state_d = StFetch;
          end
        end else if (mem_ready) begin
          state_d = StWb;
        end
      end

      StWb: begin
        cw.da     = rd;
        cw.wr     = 1'b1;
        cw.en_mem = 1'b1;
        cw.ps     = PsInc;
        state_d   = StFetch;
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StHalt;
      end
    endcase
  end

  assign k           = k_q;
  assign controlWord = cw;
  assign state       = state_q;
  assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a stimulus process drives random
// instruction streams and pushes the per-cycle expected outputs; a monitor pops and
// compares on every falling edge. A second instance with B.cond disabled is checked
// only on selected cycles.
module tb_multicycle_control_unit;

  localparam logic [31:0] CwFetch = 32'h8000_0000;

  logic        clock = 1'b1;
  logic        reset;
  logic [31:0] instruction;
  logic [3:0]  status;
  logic        mem_ready;
  logic [63:0] k, nb_k;
  logic [31:0] cw, nb_cw;
  logic [2:0]  st, nb_st;
  logic        halted, nb_halted;

  always #5 clock = ~clock;

  multicycle_control_unit #(.DATA_WIDTH(64), .ENABLE_BCOND(1'b1)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .status(status),
    .mem_ready(mem_ready), .k(k), .controlWord(cw), .state(st), .halted(halted)
  );

  multicycle_control_unit #(.DATA_WIDTH(64), .ENABLE_BCOND(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .instruction(instruction), .status(status),
    .mem_ready(mem_ready), .k(nb_k), .controlWord(nb_cw), .state(nb_st),
    .halted(nb_halted)
  );

  typedef struct {
    logic [2:0]  state;
    logic [31:0] cw;
    logic [63:0] k;
    logic        halted;
    bit          nb_chk;
    bit          nb_kchk;
    logic [2:0]  nb_state;
    logic [31:0] nb_cw;
    logic        nb_halted;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] mk;   // model's view of k

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: one expectation per clock cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("state", 64'(st), 64'(e.state));
        chk("controlWord", 64'(cw), 64'(e.cw));
        chk("k", k, e.k);
        chk("halted", 64'(halted), 64'(e.halted));
        if (e.nb_chk) begin
          chk("nb_state", 64'(nb_st), 64'(e.nb_state));
          chk("nb_controlWord", 64'(nb_cw), 64'(e.nb_cw));
          chk("nb_halted", 64'(nb_halted), 64'(e.nb_halted));
        end
        if (e.nb_kchk) chk("nb_k", nb_k, 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t fx(input logic [2:0] s, input logic [31:0] c, input logic [63:0] kk,
                              input logic h);
    exp_t e;
    e.state = s; e.cw = c; e.k = kk; e.halted = h;
    e.nb_chk = 1'b0; e.nb_kchk = 1'b0;
    e.nb_state = 3'd0; e.nb_cw = 32'd0; e.nb_halted = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] pack(input int unsigned da, sa, sb, fs, wr, wm, en_mem, en_alu,
                                       ps, selb);
    return 32'(da + (sa << 5) + (sb << 10) + (fs << 15) + (wr << 20) + (wm << 21) +
               (en_mem << 22) + (en_alu << 23) + (ps << 26) + (selb << 29));
  endfunction

  function automatic string classify(input logic [31:0] i);
    logic [10:0] t11;
    logic [9:0]  t10;
    logic [7:0]  t8;
    logic [5:0]  t6;
    t11 = i[31:21]; t10 = i[31:22]; t8 = i[31:24]; t6 = i[31:26];
    if (t11 == 11'b10001011000) return "ADD";
    if (t11 == 11'b11001011000) return "SUB";
    if (t11 == 11'b10001010000) return "AND";
    if (t11 == 11'b10101010000) return "ORR";
    if (t10 == 10'b1001000100) return "ADDI";
    if (t10 == 10'b1101000100) return "SUBI";
    if (t10 == 10'b1001001000) return "ANDI";
    if (t10 == 10'b1011001000) return "ORRI";
    if (t11 == 11'b11111000010) return "LDUR";
    if (t11 == 11'b11111000000) return "STUR";
    if (t6 == 6'b000101) return "B";
    if (t8 == 8'b10110100) return "CBZ";
    if (t8 == 8'b10110101) return "CBNZ";
    if (t8 == 8'b01010100) return "BCOND";
    return "ILL";
  endfunction

  function automatic bit is_r(input string kd);
    return kd == "ADD" || kd == "SUB" || kd == "AND" || kd == "ORR";
  endfunction

  function automatic bit is_i(input string kd);
    return kd == "ADDI" || kd == "SUBI" || kd == "ANDI" || kd == "ORRI";
  endfunction

  function automatic int unsigned fs_of(input string kd);
    if (kd == "SUB" || kd == "SUBI") return 9;
    if (kd == "AND" || kd == "ANDI") return 0;
    if (kd == "ORR" || kd == "ORRI") return 4;
    return 8;
  endfunction

  function automatic logic [63:0] kext(input logic [31:0] i, input string kd);
    longint v;
    v = 0;
    if (is_i(kd)) begin
      v = longint'((i >> 10) & 32'hFFF);
    end else if (kd == "LDUR" || kd == "STUR") begin
      v = longint'((i >> 12) & 32'h1FF);
      if (v >= 256) v -= 512;
    end else if (kd == "B") begin
      v = longint'(i & 32'h3FF_FFFF);
      if (v >= 64'h200_0000) v -= 64'h400_0000;
    end else if (kd == "CBZ" || kd == "CBNZ" || kd == "BCOND") begin
      v = longint'((i >> 5) & 32'h7_FFFF);
      if (v >= 64'h4_0000) v -= 64'h8_0000;
    end
    return 64'(v);
  endfunction

  function automatic bit cond_model(input int unsigned cond, input logic [3:0] s);
    bit z, n, c, v, r;
    z = s[0]; n = s[1]; c = s[2]; v = s[3];
    case (cond)
      0:  r = z;
      1:  r = !z;
      2:  r = c;
      3:  r = !c;
      4:  r = n;
      5:  r = !n;
      6:  r = v;
      7:  r = !v;
      8:  r = c && !z;
      9:  r = !(c && !z);
      10: r = (n == v);
      11: r = (n != v);
      12: r = !z && (n == v);
      13: r = !(!z && (n == v));
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exec_cw(input logic [31:0] i, input string kd,
                                          input logic [3:0] s);
    int unsigned rd, rn, rm;
    rd = i[4:0]; rn = i[9:5]; rm = i[20:16];
    if (is_r(kd))      return pack(rd, rn, rm, fs_of(kd), 1, 0, 0, 1, 1, 0);
    if (is_i(kd))      return pack(rd, rn, rm, fs_of(kd), 1, 0, 0, 1, 1, 1);
    if (kd == "LDUR")  return pack(0, rn, 0, 8, 0, 0, 0, 1, 0, 1);
    if (kd == "STUR")  return pack(0, rn, rd, 8, 0, 0, 0, 1, 0, 1);
    if (kd == "B")     return pack(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    if (kd == "CBZ")   return pack(0, 0, rd, 12, 0, 0, 0, 1, s[0] ? 2 : 1, 0);
    if (kd == "CBNZ")  return pack(0, 0, rd, 12, 0, 0, 0, 1, s[0] ? 1 : 2, 0);
    if (kd == "BCOND") return pack(0, 0, 0, 0, 0, 0, 0, 0, cond_model(i[3:0], s) ? 2 : 1, 0);
    return 32'd0;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic step(input logic mr, input exp_t e);
    mem_ready = mr;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Asserts reset mid-cycle for one cycle; both instances must show reset values at once.
  task automatic do_reset();
    exp_t e;
    reset = 1'b0;
    e = fx(3'd0, CwFetch, 64'd0, 1'b0);
    e.nb_chk = 1'b1; e.nb_kchk = 1'b1;
    e.nb_state = 3'd0; e.nb_cw = CwFetch; e.nb_halted = 1'b0;
    step(rb(), e);
    reset = 1'b1;
    mk = '0;
  endtask

  task automatic run_insn(input logic [31:0] insn, input int fw, input int mw, input int hc,
                          input int st_force, input bit abort_mem);
    string       kd;
    logic [3:0]  s;
    logic [31:0] mem_cw;
    for (int c = 0; c < fw; c++) begin
      instruction = $urandom;
      step(1'b0, fx(3'd0, CwFetch, mk, 1'b0));
    end
    instruction = insn;
    step(1'b1, fx(3'd0, CwFetch, mk, 1'b0));
    kd = classify(insn);
    mk = kext(insn, kd);
    s = (st_force < 0) ? 4'($urandom) : 4'(st_force);
    status = s;
    instruction = $urandom;
    step(rb(), fx(3'd1, exec_cw(insn, kd, s), mk, 1'b0));
    if (kd == "LDUR" || kd == "STUR") begin
      mem_cw = (kd == "STUR") ? pack(0, 0, insn[4:0], 0, 0, 1, 1, 0, 0, 0)
                              : pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int c = 0; c < mw; c++) begin
        status = $urandom;
        step(1'b0, fx(3'd2, mem_cw, mk, 1'b0));
      end
      if (abort_mem) begin
        do_reset();
        return;
      end
      if (kd == "STUR") begin
        step(1'b1, fx(3'd2, mem_cw | pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mk, 1'b0));
      end else begin
        step(1'b1, fx(3'd2, mem_cw, mk, 1'b0));
        step(rb(), fx(3'd3, pack(insn[4:0], 0, 0, 0, 1, 0, 1, 0, 1, 0), mk, 1'b0));
      end
    end else if (kd == "ILL") begin
      for (int c = 0; c < hc; c++) begin
        status = $urandom;
        step(rb(), fx(3'd4, 32'd0, mk, 1'b1));
      end
      do_reset();
    end
  endtask

  // B.EQ with Z=1: the full instance branches, the reduced one halts.
  task automatic bcond_directed();
    exp_t e;
    do_reset();
    instruction = 32'h5400_0040;
    status = 4'b0001;
    e = fx(3'd0, CwFetch, mk, 1'b0);
    e.nb_chk = 1'b1; e.nb_state = 3'd0; e.nb_cw = CwFetch; e.nb_halted = 1'b0;
    step(1'b1, e);
    mk = 64'd2;
    instruction = $urandom;
    e = fx(3'd1, 32'h0800_0000, mk, 1'b0);
    e.nb_chk = 1'b1; e.nb_state = 3'd1; e.nb_cw = 32'd0; e.nb_halted = 1'b0;
    step(rb(), e);
    e = fx(3'd0, CwFetch, mk, 1'b0);
    e.nb_chk = 1'b1; e.nb_state = 3'd4; e.nb_cw = 32'd0; e.nb_halted = 1'b1;
    step(1'b0, e);
    step(1'b0, e);
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(15, 0))
      0:  return {11'b10001011000, r[20:0]};
      1:  return {11'b11001011000, r[20:0]};
      2:  return {11'b10001010000, r[20:0]};
      3:  return {11'b10101010000, r[20:0]};
      4:  return {10'b1001000100, r[21:0]};
      5:  return {10'b1101000100, r[21:0]};
      6:  return {10'b1001001000, r[21:0]};
      7:  return {10'b1011001000, r[21:0]};
      8:  return {11'b11111000010, r[20:0]};
      9:  return {11'b11111000000, r[20:0]};
      10: return {6'b000101, r[25:0]};
      11: return {8'b10110100, r[23:0]};
      12: return {8'b10110101, r[23:0]};
      13: return {8'b01010100, r[23:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    instruction = 32'd0;
    status = 4'd0;
    mk = '0;
    #1;
    do_reset();
    run_insn(32'h9100_1441, 0, 0, 0, -1, 1'b0);  // ADDI: k=5, DA=1, SA=2
    run_insn(32'hF85F_8083, 2, 3, 0, -1, 1'b0);  // LDUR: k=-8, MEM held 4 cycles
    run_insn(32'hB400_0065, 0, 0, 0, 1, 1'b0);   // CBZ taken (Z=1)
    run_insn(32'hB400_0065, 1, 0, 0, 0, 1'b0);   // CBZ not taken (Z=0)
    run_insn(32'hF85F_8083, 0, 2, 0, -1, 1'b1);  // reset during MEM stall
    bcond_directed();
    run_insn(32'h0000_0000, 0, 0, 10, -1, 1'b0); // illegal: HALT for 10 cycles
    for (int n = 0; n < 250; n++) begin
      run_insn(rand_insn(), $urandom_range(2, 0), $urandom_range(3, 0), $urandom_range(4, 1),
               -1, 1'b0);
    end
    for (int w = 0; w < 20 && sb_q.size() > 0; w++) @(negedge clock);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
